// File: rtl/rf215_lvds_tx.sv
// rf215_lvds_tx: frames 14-bit I/Q pairs into 32-bit AT86RF215 LVDS words and shifts them out two bits per txclk.
module rf215_lvds_tx #(
  parameter int WORD_BITS  = 32,
  parameter int ZERO_WORDS = 2,
  parameter int CNT_W      = 16
) (
  input  logic             txclk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [13:0]      s_i,
  input  logic [13:0]      s_q,
  output logic [1:0]       bit_pair,
  output logic             word_start,
  output logic             tx_active,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);
  localparam int CW = $clog2(WORD_BITS / 2);
  typedef enum logic [1:0] {IDLE, PREAMBLE, STREAM} state_t;
  state_t               r_state, w_next_state;
  logic [WORD_BITS-1:0] r_shift;
  logic [CW-1:0]        r_bit_cnt;
  logic                 r_hold_valid;
  logic [13:0]          r_hold_i, r_hold_q;
  logic [7:0]           r_pre_cnt, w_next_pre;
  logic                 r_word_start, r_tx_active, r_underrun;
  logic [CNT_W-1:0]     r_underrun_cnt;
  logic                 w_boundary, w_accept, w_load_data, w_underrun, w_drop;
  assign w_boundary   = r_bit_cnt == CW'(WORD_BITS / 2 - 1);
  assign w_accept     = s_valid && !r_hold_valid;
  assign w_load_data  = w_boundary && r_state == STREAM && tx_en && r_hold_valid;
  assign w_underrun   = w_boundary && r_state == STREAM && tx_en && !r_hold_valid;
  // a sample held when streaming stops (or offered while idle) is never sent
  assign w_drop       = w_boundary && (r_state == IDLE || (r_state == STREAM && !tx_en));
  assign s_ready      = !r_hold_valid;
  assign bit_pair     = r_shift[WORD_BITS-1 -: 2];
  assign word_start   = r_word_start;
  assign tx_active    = r_tx_active;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;
  always_comb begin
    w_next_state = r_state;
    w_next_pre   = r_pre_cnt;
    if (w_boundary) begin
      case (r_state)
        IDLE: if (tx_en) begin
          w_next_state = ZERO_WORDS <= 1 ? STREAM : PREAMBLE;
          w_next_pre   = 8'd1;
        end
        PREAMBLE: if (!tx_en) w_next_state = IDLE;
        else begin
          w_next_pre   = r_pre_cnt + 8'd1;
          w_next_state = int'(r_pre_cnt) + 1 >= ZERO_WORDS ? STREAM : PREAMBLE;
        end
        STREAM: if (!tx_en) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge txclk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_hold_valid   <= 1'b0;
      r_pre_cnt      <= '0;
      r_word_start   <= 1'b0;
      r_tx_active    <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_bit_cnt    <= w_boundary ? '0 : r_bit_cnt + 1'b1;
      r_shift      <= w_boundary ? (w_load_data ? WORD_BITS'({2'b10, r_hold_i, 2'b01, r_hold_q}) : '0)
                                 : r_shift << 2;
      r_word_start <= w_boundary;
      r_underrun   <= w_underrun;
      if (w_underrun && !(&r_underrun_cnt)) r_underrun_cnt <= r_underrun_cnt + 1'b1;
      r_hold_valid <= (w_load_data || w_drop) ? 1'b0 : (w_accept ? 1'b1 : r_hold_valid);
      if (w_accept) begin
        r_hold_i <= s_i;
        r_hold_q <= s_q;
      end
      r_state     <= w_next_state;
      r_pre_cnt   <= w_next_pre;
      r_tx_active <= w_next_state != IDLE;
    end
  end
endmodule

// File: tb/tb_rf215_lvds_tx.sv
// tb_rf215_lvds_tx: directed checks of framing, preamble, underrun, tx_en drop and reset for rf215_lvds_tx.
module tb_rf215_lvds_tx;
  logic        clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, s_valid = 1'b0, s_ready;
  logic [13:0] s_i = '0, s_q = '0;
  logic [1:0]  bit_pair;
  logic        word_start, tx_active, underrun, hs = 1'b0;
  logic [15:0] underrun_cnt;
  int          vectors = 0, errors = 0;
  typedef struct {logic [13:0] i; logic [13:0] q;} samp_t;
  samp_t       sq[$];
  rf215_lvds_tx dut (
    .txclk(clk), .rst_n(rst_n), .tx_en(tx_en), .s_valid(s_valid), .s_ready(s_ready),
    .s_i(s_i), .s_q(s_q), .bit_pair(bit_pair), .word_start(word_start),
    .tx_active(tx_active), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) hs <= s_valid && s_ready;
  // sample driver: presents the queue head until it is taken
  always @(negedge clk) begin
    if (hs && sq.size() != 0) sq.delete(0);
    s_valid = sq.size() != 0;
    s_i     = s_valid ? sq[0].i : '0;
    s_q     = s_valid ? sq[0].q : '0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic get_word(input string tag, output logic [31:0] w, output logic u0, output logic u1, input int drop);
    int n = 0;
    @(negedge clk);
    while (word_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ws"}, {31'd0, word_start}, 32'd1);
    w  = '0;
    u0 = 1'b0;
    u1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      w = {w[29:0], bit_pair};
      if (k == 0) u0 = underrun;
      if (k == 1) u1 = underrun;
      if (k == drop) tx_en = 1'b0;
    end
  endtask
  initial begin
    logic [31:0] w;
    logic [15:0] hw;
    logic        u0, u1;
    int          n;
    repeat (3) @(negedge clk);
    chk("rst_bp", {30'd0, bit_pair}, 32'd0);
    chk("rst_ws", {31'd0, word_start}, 32'd0);
    chk("rst_act", {31'd0, tx_active}, 32'd0);
    chk("rst_ur", {31'd0, underrun}, 32'd0);
    chk("rst_rdy", {31'd0, s_ready}, 32'd1);
    chk("rst_cnt", {16'd0, underrun_cnt}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("idle_bp", {30'd0, bit_pair}, 32'd0);
      chk("idle_ws", {31'd0, word_start}, (k % 16 == 0) ? 32'd1 : 32'd0);
      chk("idle_rdy", {31'd0, s_ready}, 32'd1);
    end
    chk("idle_cnt", {16'd0, underrun_cnt}, 32'd0);
    chk("idle_act", {31'd0, tx_active}, 32'd0);
    tx_en = 1'b1;
    get_word("b_z1", w, u0, u1, -1);
    chk("b_z1", w, 32'h0);
    chk("b_z1_ur", {31'd0, u0}, 32'd0);
    chk("b_act", {31'd0, tx_active}, 32'd1);
    sq.push_back('{14'h1ABC, 14'h0123});
    sq.push_back('{14'h2000, 14'h1FFF});
    sq.push_back('{14'h0000, 14'h0000});
    get_word("b_z2", w, u0, u1, -1);
    chk("b_z2", w, 32'h0);
    chk("b_z2_ur", {31'd0, u0}, 32'd0);
    get_word("b_d0", w, u0, u1, -1);
    chk("b_d0", w, 32'h9ABC4123);
    chk("c_rdy_full", {31'd0, s_ready}, 32'd0);
    get_word("c_d1", w, u0, u1, -1);
    chk("c_d1", w, 32'hA0005FFF);
    get_word("c_d2", w, u0, u1, -1);
    chk("c_d2", w, 32'h80004000);
    chk("c_d2_ur", {31'd0, u0}, 32'd0);
    get_word("d_u1", w, u0, u1, -1);
    chk("d_u1", w, 32'h0);
    chk("d_u1_pulse", {31'd0, u0}, 32'd1);
    chk("d_u1_len", {31'd0, u1}, 32'd0);
    chk("d_u1_cnt", {16'd0, underrun_cnt}, 32'd1);
    get_word("d_u2", w, u0, u1, -1);
    chk("d_u2", w, 32'h0);
    chk("d_u2_pulse", {31'd0, u0}, 32'd1);
    chk("d_u2_cnt", {16'd0, underrun_cnt}, 32'd2);
    sq.push_back('{14'h1555, 14'h2AAA});
    sq.push_back('{14'h0AAA, 14'h1555});
    sq.push_back('{14'h3FFF, 14'h3FFF});
    get_word("d_u3", w, u0, u1, -1);
    chk("d_u3", w, 32'h0);
    chk("d_u3_pulse", {31'd0, u0}, 32'd1);
    chk("d_u3_cnt", {16'd0, underrun_cnt}, 32'd3);
    get_word("d_data", w, u0, u1, -1);
    chk("d_data", w, 32'h95556AAA);
    chk("d_data_ur", {31'd0, u0}, 32'd0);
    get_word("e_last", w, u0, u1, 7);
    chk("e_last", w, 32'h8AAA5555);
    chk("e_rdy_held", {31'd0, s_ready}, 32'd0);
    chk("e_act_mid", {31'd0, tx_active}, 32'd1);
    get_word("e_z", w, u0, u1, -1);
    chk("e_z", w, 32'h0);
    chk("e_z_ur", {31'd0, u0}, 32'd0);
    chk("e_act", {31'd0, tx_active}, 32'd0);
    chk("e_rdy", {31'd0, s_ready}, 32'd1);
    get_word("e_idle", w, u0, u1, -1);
    chk("e_idle", w, 32'h0);
    chk("e_cnt", {16'd0, underrun_cnt}, 32'd3);
    tx_en = 1'b1;
    get_word("f_z1", w, u0, u1, -1);
    chk("f_z1", w, 32'h0);
    chk("f_act", {31'd0, tx_active}, 32'd1);
    sq.push_back('{14'h3FFF, 14'h0001});
    get_word("f_z2", w, u0, u1, -1);
    chk("f_z2", w, 32'h0);
    n = 0;
    @(negedge clk);
    while (word_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("f_ws", {31'd0, word_start}, 32'd1);
    hw = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      hw = {hw[13:0], bit_pair};
    end
    chk("f_half", {16'd0, hw}, 32'h0000BFFF);
    chk("f_cnt_pre", {16'd0, underrun_cnt}, 32'd3);
    rst_n = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    chk("f_rst_bp", {30'd0, bit_pair}, 32'd0);
    chk("f_rst_cnt", {16'd0, underrun_cnt}, 32'd0);
    chk("f_rst_act", {31'd0, tx_active}, 32'd0);
    chk("f_rst_rdy", {31'd0, s_ready}, 32'd1);
    chk("f_rst_ws", {31'd0, word_start}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (word_start !== 1'b1 && n < 40);
    chk("f_restart", n, 32'd16);
    chk("f_restart_bp", {30'd0, bit_pair}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
